// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780-compatible LCD bus timing generator fed by a byte-wide
// valid/ready request port. Drives RS/RW/EN/DATA packed as
// {ON, 20'b0, EN, RS, RW, DATA} on io_lcd_o. All outputs are registered.
// Optional feature macro: LCD_INIT_EN (power-up wait plus internal init
// command sequence). Without it the controller is idle one cycle after ON.
module lcd_ctrl #(
  parameter int SETUP_CYC      = 4,
  parameter int EN_HIGH_CYC    = 24,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int PWRUP_WAIT_CYC = 750000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_rs_i,
  input  logic [7:0]  req_data_i,
  output logic        req_ready_o,
  output logic        init_done_o,
  output logic [31:0] io_lcd_o
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max_of(max_of(max_of(SETUP_CYC, EN_HIGH_CYC),
                                         max_of(CMD_WAIT_CYC, CLEAR_WAIT_CYC)),
                                  PWRUP_WAIT_CYC);
  localparam int CNT_W = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_INIT  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_SETUP = 3'd3,
    ST_PULSE = 3'd4,
    ST_WAIT  = 3'd5
  } state_t;

  // Clear/home commands need the long post-pulse wait.
  function automatic logic [CNT_W-1:0] wait_len(input logic rs, input logic [7:0] d);
    if (!rs && ((d == 8'h01) || (d == 8'h02) || (d == 8'h03))) begin
      return CNT_W'(CLEAR_WAIT_CYC);
    end else begin
      return CNT_W'(CMD_WAIT_CYC);
    end
  endfunction

  // Fixed power-up command list: function set, display on, clear, entry mode.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      2'd3:    return 8'h06;
      default: return 8'h00;
    endcase
  endfunction

  state_t           state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             on_r;
  logic             en_r, en_next_s;
  logic             rs_r, rs_next_s;
  logic [7:0]       data_r, data_next_s;
  logic             ready_r, ready_next_s;
  logic             init_done_r, init_done_next_s;
  logic [1:0]       idx_r, idx_next_s;

  // Next-state and next-output decode; every counted phase advances when the counter reads 1.
  always_comb begin
    state_next_s     = state_r;
    cnt_next_s       = cnt_r;
    en_next_s        = 1'b0;
    rs_next_s        = rs_r;
    data_next_s      = data_r;
    ready_next_s     = 1'b0;
    init_done_next_s = init_done_r;
    idx_next_s       = idx_r;
    case (state_r)
      ST_PWRUP: begin
`ifdef LCD_INIT_EN
        if (!on_r) begin
          cnt_next_s = CNT_W'(PWRUP_WAIT_CYC);
        end else if (cnt_r <= CNT_W'(1)) begin
          state_next_s = ST_INIT;
        end else begin
          cnt_next_s = cnt_r - CNT_W'(1);
        end
`else
        if (on_r) begin
          state_next_s     = ST_IDLE;
          ready_next_s     = 1'b1;
          init_done_next_s = 1'b1;
        end else begin
          state_next_s = ST_PWRUP;
        end
`endif
      end
      ST_INIT: begin
        state_next_s = ST_SETUP;
        rs_next_s    = 1'b0;
        data_next_s  = init_cmd(idx_r);
        cnt_next_s   = CNT_W'(SETUP_CYC);
      end
      ST_IDLE: begin
        if (req_valid_i && ready_r) begin
          state_next_s = ST_SETUP;
          rs_next_s    = req_rs_i;
          data_next_s  = req_data_i;
          cnt_next_s   = CNT_W'(SETUP_CYC);
        end else begin
          ready_next_s = 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt_r == CNT_W'(1)) begin
          state_next_s = ST_PULSE;
          cnt_next_s   = CNT_W'(EN_HIGH_CYC);
          en_next_s    = 1'b1;
        end else begin
          cnt_next_s = cnt_r - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_r == CNT_W'(1)) begin
          state_next_s = ST_WAIT;
          cnt_next_s   = wait_len(rs_r, data_r);
        end else begin
          cnt_next_s = cnt_r - CNT_W'(1);
          en_next_s  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_r != CNT_W'(1)) begin
          cnt_next_s = cnt_r - CNT_W'(1);
        end else if (init_done_r) begin
          state_next_s = ST_IDLE;
          ready_next_s = 1'b1;
        end else if (idx_r == 2'd3) begin
          state_next_s     = ST_IDLE;
          ready_next_s     = 1'b1;
          init_done_next_s = 1'b1;
          idx_next_s       = 2'd0;
        end else begin
          state_next_s = ST_INIT;
          idx_next_s   = idx_r + 2'd1;
        end
      end
      default: begin
        state_next_s = ST_PWRUP;
      end
    endcase
  end

  // State, counter and output registers; reset drops EN and forgets any request at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_PWRUP;
      cnt_r       <= '0;
      on_r        <= 1'b0;
      en_r        <= 1'b0;
      rs_r        <= 1'b0;
      data_r      <= 8'h00;
      ready_r     <= 1'b0;
      init_done_r <= 1'b0;
      idx_r       <= 2'd0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      on_r        <= 1'b1;
      en_r        <= en_next_s;
      rs_r        <= rs_next_s;
      data_r      <= data_next_s;
      ready_r     <= ready_next_s;
      init_done_r <= init_done_next_s;
      idx_r       <= idx_next_s;
    end
  end

  assign req_ready_o = ready_r;
  assign init_done_o = init_done_r;
  assign io_lcd_o    = {on_r, 20'b0, en_r, rs_r, 1'b0, data_r};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: cycle-number based reference model,
// per-cycle comparison, directed scenarios and a randomized request phase.
module tb_lcd_ctrl;
  localparam int S = 2;
  localparam int H = 3;
  localparam int W = 5;
  localparam int C = 20;
  localparam int P = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_rs = 1'b0;
  logic [7:0]  req_data = 8'h00;
  logic        req_ready;
  logic        init_done;
  logic [31:0] io_lcd;

  int checks = 0;
  int errors = 0;

  lcd_ctrl #(
    .SETUP_CYC(S), .EN_HIGH_CYC(H), .CMD_WAIT_CYC(W),
    .CLEAR_WAIT_CYC(C), .PWRUP_WAIT_CYC(P)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_rs_i(req_rs),
    .req_data_i(req_data), .req_ready_o(req_ready), .init_done_o(init_done),
    .io_lcd_o(io_lcd)
  );

  always #5 clk = ~clk;

  // Reference model: everything derives from the cycle number of the last acceptance.
  int         cyc = 0;
  int         acc = -1000;
  int         busy_end = 0;
  int         ready_base = 2;
  int         next_init = -1;
  int         init_n = 0;
  logic       m_rs = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ready = 1'b0;
  logic [7:0] init_cmds [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  function automatic int wait_of(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? C : W;
  endfunction

  // Model update at each rising edge; async reset clears it like the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc      <= 0;
      acc      <= -1000;
      busy_end <= 0;
      m_rs     <= 1'b0;
      m_data   <= 8'h00;
      m_ready  <= 1'b0;
      init_n   <= 0;
`ifdef LCD_INIT_EN
      next_init  <= P + 2;
      ready_base <= 1 << 30;
`else
      next_init  <= -1;
      ready_base <= 2;
`endif
    end else begin
      cyc <= cyc + 1;
      if (m_ready && req_valid) begin
        acc      <= cyc + 1;
        m_rs     <= req_rs;
        m_data   <= req_data;
        busy_end <= cyc + 1 + S + H + wait_of(req_rs, req_data);
        m_ready  <= 1'b0;
      end else if (init_n < 4 && cyc + 1 == next_init) begin
        acc      <= cyc + 1;
        m_rs     <= 1'b0;
        m_data   <= init_cmds[init_n];
        busy_end <= cyc + 1 + S + H + wait_of(1'b0, init_cmds[init_n]);
        init_n   <= init_n + 1;
        if (init_n == 3) ready_base <= cyc + 1 + S + H + wait_of(1'b0, init_cmds[init_n]);
        else next_init <= cyc + 2 + S + H + wait_of(1'b0, init_cmds[init_n]);
        m_ready  <= 1'b0;
      end else begin
        m_ready <= (cyc + 1 >= ready_base) && (cyc + 1 >= busy_end);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic en_e;
    logic on_e;
    en_e = (cyc >= acc + S) && (cyc < acc + S + H);
    on_e = (cyc >= 1);
    chk("io_lcd", io_lcd, {on_e, 20'b0, en_e, m_rs, 1'b0, m_data});
    chk("req_ready", {31'b0, req_ready}, {31'b0, m_ready});
    chk("init_done", {31'b0, init_done}, {31'b0, (cyc >= ready_base)});
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
  endtask

  // Present a request and hold it until accepted; n = cycles spent waiting for ready.
  task automatic send(input logic rs, input logic [7:0] d, output int n);
    n = 0;
    req_valid = 1'b1; req_rs = rs; req_data = d;
    while (!req_ready && n < 300) begin tick(); n++; end
    chk("send_ready", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // Called right after the acceptance edge: cycles until ready returns and EN-high cycles.
  task automatic measure(output int lat, output int enc, output logic [31:0] en_io);
    lat = 0; enc = 0; en_io = 32'h0;
    while (!req_ready && lat < 300) begin
      if (io_lcd[10]) begin enc++; en_io = io_lcd; end
      tick();
      lat++;
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!req_ready && n < 300) begin tick(); n++; end
    chk(name, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int lat, enc, n;
    logic [31:0] en_io;
    logic was_ready;

    repeat (2) tick();
    chk("reset_io", io_lcd, 32'h0);
    chk("reset_ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;
    tick();
`ifndef LCD_INIT_EN
    chk("pwrup_on", io_lcd, 32'h8000_0000);
    chk("pwrup_ready", {31'b0, req_ready}, 32'd0);
    tick();
    chk("idle_ready", {31'b0, req_ready}, 32'd1);
    chk("idle_done", {31'b0, init_done}, 32'd1);
`else
    wait_ready("init_ready");
    chk("init_done_lit", {31'b0, init_done}, 32'd1);
    chk("init_last_cmd", io_lcd, 32'h8000_0006);
`endif

    // Character write and command latencies.
    send(1'b1, 8'h41, n);
    measure(lat, enc, en_io);
    chk("data_latency", lat, 32'd10);
    chk("data_en_cycles", enc, 32'd3);
    chk("data_en_word", en_io, 32'h8000_0641);
    send(1'b0, 8'h01, n);
    measure(lat, enc, en_io);
    chk("clear_latency", lat, 32'd25);
    chk("clear_en_cycles", enc, 32'd3);
    send(1'b0, 8'h38, n);
    measure(lat, enc, en_io);
    chk("cmd_latency", lat, 32'd10);

    // Back-to-back: valid stays high, each byte accepted on the first ready cycle.
    send(1'b1, 8'h61, n);
    send(1'b1, 8'h62, n);
    chk("b2b_wait1", n, 32'd10);
    send(1'b1, 8'h63, n);
    chk("b2b_wait2", n, 32'd10);
    wait_ready("b2b_drain");

    // Input churn while busy must not reach the bus.
    send(1'b1, 8'h5A, n);
    for (int i = 0; i < 6; i++) begin
      req_data = 8'($urandom);
      req_rs = 1'($urandom);
      tick();
    end
    chk("hold_data", {24'h0, io_lcd[7:0]}, 32'h5A);
    wait_ready("hold_drain");

    // Reset in the middle of the EN pulse.
    send(1'b1, 8'h55, n);
    n = 0;
    while (!io_lcd[10] && n < 50) begin tick(); n++; end
    chk("pulse_seen", {31'b0, io_lcd[10]}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_io", io_lcd, 32'h0);
    chk("async_rst_ready", {31'b0, req_ready}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    wait_ready("restart_ready");

    // Randomized traffic, protocol-compliant requester.
    for (int i = 0; i < 1500; i++) begin
      was_ready = req_ready;
      tick();
      if (!req_valid || was_ready) begin
        req_valid = ($urandom_range(0, 2) != 0);
        req_rs = 1'($urandom);
        if ($urandom_range(0, 3) == 0) req_data = 8'($urandom_range(0, 3));
        else req_data = 8'($urandom);
      end
    end
    req_valid = 1'b0;
    wait_ready("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
